// File: rtl/board_dump_streamer.sv
// board_dump_streamer: reads the 81-cell board out of board_memory in row-major
// order and streams one cell per valid/ready transfer. It also counts the blank
// (0) and illegal (10..15) cells seen during the dump.
module board_dump_streamer #(
  parameter int unsigned N_CELLS    = 81,
  parameter int unsigned ROW_LEN    = 9,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       mem_read_en,
  output logic [6:0] mem_cell_idx,
  input  logic [3:0] mem_data_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic [6:0] out_index,
  output logic       out_eol,
  output logic       out_last,
  output logic       busy,
  output logic       dump_done,
  output logic [6:0] blank_cnt,
  output logic [6:0] illegal_cnt
);

  localparam int unsigned IDX_W  = 7;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned CNT_W  = 7;
  localparam int unsigned LAT_W  = 2;
  localparam int unsigned COL_W  = 4;

  localparam logic [IDX_W-1:0]  LAST_IDX      = IDX_W'(N_CELLS - 1);
  localparam logic [COL_W-1:0]  LAST_COL      = COL_W'(ROW_LEN - 1);
  localparam logic [LAT_W-1:0]  LAST_WAIT     = LAT_W'(RD_LATENCY - 1);
  localparam logic [DATA_W-1:0] FIRST_ILLEGAL = DATA_W'(10);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_PRESENT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [COL_W-1:0] col;
  logic [LAT_W-1:0] wait_cnt;
  logic             handshake_c;

  // A word leaves the block only when both sides agree in the same cycle.
  assign handshake_c = out_valid && out_ready;

  // Dump sequencer: one outstanding read, captured after the memory latency and
  // held on the stream until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      idx          <= '0;
      col          <= '0;
      wait_cnt     <= '0;
      mem_read_en  <= 1'b0;
      mem_cell_idx <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_index    <= '0;
      out_eol      <= 1'b0;
      out_last     <= 1'b0;
      busy         <= 1'b0;
      dump_done    <= 1'b0;
      blank_cnt    <= '0;
      illegal_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            idx          <= '0;
            col          <= '0;
            blank_cnt    <= '0;
            illegal_cnt  <= '0;
            busy         <= 1'b1;
            mem_cell_idx <= '0;
            mem_read_en  <= 1'b1;
            state        <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          // The strobe was raised on entry; it lasts exactly this one cycle.
          mem_read_en <= 1'b0;
          wait_cnt    <= '0;
          state       <= S_WAIT;
        end

        S_WAIT: begin
          if (wait_cnt == LAST_WAIT) begin
            out_data  <= mem_data_out;
            out_index <= idx;
            out_eol   <= (col == LAST_COL);
            out_last  <= (idx == LAST_IDX);
            out_valid <= 1'b1;
            if (mem_data_out == '0) begin
              blank_cnt <= blank_cnt + CNT_W'(1);
            end
            if (mem_data_out >= FIRST_ILLEGAL) begin
              illegal_cnt <= illegal_cnt + CNT_W'(1);
            end
            state <= S_PRESENT;
          end else begin
            wait_cnt <= wait_cnt + LAT_W'(1);
          end
        end

        S_PRESENT: begin
          if (handshake_c) begin
            out_valid <= 1'b0;
            if (out_last) begin
              dump_done <= 1'b1;
              state     <= S_DONE;
            end else begin
              idx          <= idx + IDX_W'(1);
              col          <= (col == LAST_COL) ? '0 : col + COL_W'(1);
              mem_cell_idx <= idx + IDX_W'(1);
              mem_read_en  <= 1'b1;
              state        <= S_ISSUE;
            end
          end
        end

        S_DONE: begin
          // start seen here is dropped: the block only listens in IDLE.
          dump_done <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end

        default: begin
          mem_read_en <= 1'b0;
          out_valid   <= 1'b0;
          dump_done   <= 1'b0;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_dump_streamer.sv
// Bench for board_dump_streamer: a latency-1 instance exercised through a table of
// dump scenarios plus restart/abort sequences, and a latency-3 instance for timing.
`timescale 1ns/1ps
module tb_board_dump_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- latency-1 instance ----------------
  logic       rst_n, start, mem_read_en, out_valid, out_ready, out_eol, out_last;
  logic       busy, dump_done;
  logic [6:0] mem_cell_idx, out_index, blank_cnt, illegal_cnt;
  logic [3:0] mem_data_out, out_data;

  board_dump_streamer #(.N_CELLS(81), .ROW_LEN(9), .RD_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_read_en(mem_read_en), .mem_cell_idx(mem_cell_idx), .mem_data_out(mem_data_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_eol(out_eol), .out_last(out_last),
    .busy(busy), .dump_done(dump_done), .blank_cnt(blank_cnt), .illegal_cnt(illegal_cnt)
  );

  // Memory model: data only appears for a strobed read, otherwise garbage (14).
  logic [3:0] mem1 [0:127];
  always @(posedge clk) mem_data_out <= mem_read_en ? mem1[mem_cell_idx] : 4'd14;

  // ---------------- latency-3 instance ----------------
  logic       start3, rd_en3, valid3, ready3, eol3, last3, busy3, done3;
  logic [6:0] idx3, index3, blank3, illegal3;
  logic [3:0] mdata3, data3, s0, s1;

  board_dump_streamer #(.N_CELLS(81), .ROW_LEN(9), .RD_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
    .mem_read_en(rd_en3), .mem_cell_idx(idx3), .mem_data_out(mdata3),
    .out_valid(valid3), .out_ready(ready3), .out_data(data3),
    .out_index(index3), .out_eol(eol3), .out_last(last3),
    .busy(busy3), .dump_done(done3), .blank_cnt(blank3), .illegal_cnt(illegal3)
  );

  logic [3:0] mem3 [0:127];
  always @(posedge clk) begin
    s0     <= rd_en3 ? mem3[idx3] : 4'd14;
    s1     <= s0;
    mdata3 <= s1;
  end

  // ---------------- scoreboard state ----------------
  int tests = 0, fails = 0;
  int wcnt, stall_err, overlap_err, done_cnt, done_cyc, start_cyc;
  int w_data [0:127];
  int w_idx  [0:127];
  int w_eol  [0:127];
  int w_last [0:127];
  int rd_cnt [0:127];
  logic       prev_stall;
  logic [3:0] prev_data;
  logic [6:0] prev_index;
  int w3cnt = 0, w3_err = 0, done3_cnt = 0, done3_cyc = 0;

  // Stream monitor for the latency-1 instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall && (!out_valid || out_data != prev_data || out_index != prev_index))
        stall_err++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_index = out_index;
      if (out_valid && out_ready && wcnt < 128) begin
        w_data[wcnt] = int'(out_data);
        w_idx[wcnt]  = int'(out_index);
        w_eol[wcnt]  = int'(out_eol);
        w_last[wcnt] = int'(out_last);
        wcnt++;
      end
      if (mem_read_en) begin
        rd_cnt[mem_cell_idx]++;
        if (out_valid) overlap_err++;
      end
      if (dump_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Stream monitor for the latency-3 instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid3 && ready3 && w3cnt < 128) begin
        if (int'(data3) != int'(mem3[w3cnt]) || int'(index3) != w3cnt) w3_err++;
        w3cnt++;
      end
      if (done3) begin
        done3_cnt++;
        done3_cyc = cyc;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load_mem(input int pattern, input int c40, input int c80);
    int puz [0:17];
    puz = '{5, 3, 0, 0, 7, 0, 0, 0, 0, 6, 0, 0, 1, 9, 5, 0, 0, 0};
    for (int i = 0; i < 128; i++) begin
      if (pattern == 1) mem1[i] = 4'(i % 16);
      else if (i < 18)  mem1[i] = 4'(puz[i]);
      else              mem1[i] = 4'd0;
    end
    if (c40 >= 0) mem1[40] = 4'(c40);
    if (c80 >= 0) mem1[80] = 4'(c80);
  endtask

  task automatic clear_mon();
    wcnt = 0; stall_err = 0; overlap_err = 0; done_cnt = 0; done_cyc = 0;
    prev_stall = 1'b0;
    for (int i = 0; i < 128; i++) begin
      w_data[i] = -1; w_idx[i] = -1; w_eol[i] = -1; w_last[i] = -1; rd_cnt[i] = 0;
    end
  endtask

  function automatic int seq_errs();
    int e = 0;
    for (int i = 0; i < wcnt; i++)
      if (w_data[i] != int'(mem1[i]) || w_idx[i] != i) e++;
    return e;
  endfunction

  function automatic int flag_errs();
    int e = 0;
    for (int i = 0; i < wcnt; i++) begin
      if (w_eol[i]  != ((i % 9) == 8 ? 1 : 0)) e++;
      if (w_last[i] != (i == 80 ? 1 : 0)) e++;
    end
    return e;
  endfunction

  function automatic int sum_flags(input int which);
    int s = 0;
    for (int i = 0; i < wcnt; i++) s += (which == 0) ? w_eol[i] : w_last[i];
    return s;
  endfunction

  function automatic int read_errs();
    int e = 0;
    for (int i = 0; i < 128; i++)
      if (rd_cnt[i] != ((i < 81) ? 1 : 0)) e++;
    return e;
  endfunction

  // Runs one dump; optionally re-pulses start or asserts reset at a word count.
  task automatic run_dump(input int pct, input int restart_word, input int abort_word,
                          output int timed_out);
    bit restarted = 1'b0;
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1; start_cyc = cyc;
    out_ready = ($urandom_range(99) < pct);
    @(posedge clk); #1;
    timed_out = 1;
    for (int n = 0; n < 3000; n++) begin
      start = 1'b0;
      out_ready = ($urandom_range(99) < pct);
      if (done_cnt > 0) begin
        timed_out = 0;
        break;
      end
      if (restart_word >= 0 && !restarted && wcnt >= restart_word) begin
        start = 1'b1;
        restarted = 1'b1;
      end
      if (abort_word >= 0 && wcnt >= abort_word) begin
        rst_n = 1'b0;
        #1;
        check("abort_valid", int'(out_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_rd_en", int'(mem_read_en), 0);
        check("abort_cell_idx", int'(mem_cell_idx), 0);
        check("abort_out_fields",
              int'(out_data) + int'(out_index) + int'(out_eol) + int'(out_last), 0);
        check("abort_counts", int'(blank_cnt) + int'(illegal_cnt), 0);
        check("abort_done", int'(dump_done), 0);
        timed_out = 0;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (abort_word < 0) begin
      repeat (4) @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    int pattern;
    int c40;
    int c80;
    int ready_pct;
    int exp_blank;
    int exp_illegal;
    int exp_last_data;
    int exp_cycles;
  } vec_t;

  vec_t vecs [0:4];

  initial begin
    int to;
    // pattern 0: 18-cell puzzle (7 non-zero cells); pattern 1: cell i = i%16
    vecs[0] = '{0, -1, -1, 100, 74,  0,  0, 244};
    vecs[1] = '{0, -1, -1,  30, 74,  0,  0,  -1};
    vecs[2] = '{0, 12, 15, 100, 72,  2, 15, 244};
    vecs[3] = '{0, 12, 15,  50, 72,  2, 15,  -1};
    vecs[4] = '{1, -1, -1, 100,  6, 30,  0, 244};

    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; start3 = 1'b0; ready3 = 1'b1;
    clear_mon();
    load_mem(0, -1, -1);
    for (int i = 0; i < 128; i++) mem3[i] = mem1[i];
    mem3[80] = 4'd11;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy_done", int'(busy) + int'(dump_done), 0);
    check("rst_rd_en", int'(mem_read_en), 0);
    check("rst_cell_idx", int'(mem_cell_idx), 0);
    check("rst_counts", int'(blank_cnt) + int'(illegal_cnt), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) begin
      load_mem(vecs[v].pattern, vecs[v].c40, vecs[v].c80);
      run_dump(vecs[v].ready_pct, -1, -1, to);
      check($sformatf("v%0d_timeout", v), to, 0);
      check($sformatf("v%0d_words", v), wcnt, 81);
      check($sformatf("v%0d_sequence", v), seq_errs(), 0);
      check($sformatf("v%0d_flags", v), flag_errs(), 0);
      check($sformatf("v%0d_eol_count", v), sum_flags(0), 9);
      check($sformatf("v%0d_last_count", v), sum_flags(1), 1);
      check($sformatf("v%0d_word80_last", v), w_last[80], 1);
      check($sformatf("v%0d_word80_eol", v), w_eol[80], 1);
      check($sformatf("v%0d_word80_data", v), w_data[80], vecs[v].exp_last_data);
      check($sformatf("v%0d_blank_cnt", v), int'(blank_cnt), vecs[v].exp_blank);
      check($sformatf("v%0d_illegal_cnt", v), int'(illegal_cnt), vecs[v].exp_illegal);
      check($sformatf("v%0d_stall_hold", v), stall_err, 0);
      check($sformatf("v%0d_read_overlap", v), overlap_err, 0);
      check($sformatf("v%0d_reads_per_idx", v), read_errs(), 0);
      check($sformatf("v%0d_done_pulses", v), done_cnt, 1);
      check($sformatf("v%0d_busy_after", v), int'(busy), 0);
      if (vecs[v].exp_cycles >= 0)
        check($sformatf("v%0d_done_cycle", v), done_cyc - start_cyc, vecs[v].exp_cycles);
    end

    // start re-pulsed mid-dump must not restart anything
    load_mem(0, -1, -1);
    run_dump(100, 20, -1, to);
    check("restart_timeout", to, 0);
    check("restart_words", wcnt, 81);
    check("restart_sequence", seq_errs(), 0);
    check("restart_done_pulses", done_cnt, 1);
    check("restart_reads_per_idx", read_errs(), 0);
    check("restart_blank_cnt", int'(blank_cnt), 74);

    // reset at word 50 aborts; the next dump starts over from index 0
    run_dump(100, -1, 50, to);
    repeat (2) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, 0);
    check("abort_held_valid", int'(out_valid), 0);
    rst_n = 1'b1;
    load_mem(1, -1, -1);
    run_dump(100, -1, -1, to);
    check("post_abort_timeout", to, 0);
    check("post_abort_first_idx", w_idx[0], 0);
    check("post_abort_words", wcnt, 81);
    check("post_abort_sequence", seq_errs(), 0);
    check("post_abort_blank_cnt", int'(blank_cnt), 6);
    check("post_abort_illegal_cnt", int'(illegal_cnt), 30);

    // latency-3 build: 5 cycles per cell, 81*5+1 from start to dump_done
    begin
      int s3;
      int ok3 = 0;
      @(posedge clk); #1;
      start3 = 1'b1; s3 = cyc;
      @(posedge clk); #1;
      start3 = 1'b0;
      for (int n = 0; n < 1000; n++) begin
        if (done3_cnt > 0) begin
          ok3 = 1;
          break;
        end
        @(posedge clk); #1;
      end
      check("lat3_finished", ok3, 1);
      check("lat3_done_cycle", done3_cyc - s3, 406);
      check("lat3_words", w3cnt, 81);
      check("lat3_data", w3_err, 0);
      check("lat3_blank_cnt", int'(blank3), 73);
      check("lat3_illegal_cnt", int'(illegal3), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
